// File: rtl/debug_mem_master.sv
// Debug-side dmem initiator: halts the CPU, borrows the dmem bus
// for one access per command and hands back a response.
module debug_mem_master #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 10,
  parameter int HALT_SETTLE  = 4,
  parameter int READ_LATENCY = 0
) (
  input  logic              CK_REF,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_READ_WRN,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  input  logic              DBG_HOLD,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              HALT_REQ,
  output logic              BUS_OWN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DATA_OUT,
  output logic              MEM_READ_WRN,
  input  logic [DATA_W-1:0] MEM_DATA_IN,
  output logic [15:0]       TXN_COUNT
);

  localparam int CNT_MAX =
    (HALT_SETTLE > READ_LATENCY) ? HALT_SETTLE : READ_LATENCY;
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HS_LOAD = CNT_W'(HALT_SETTLE - 1);
  localparam logic [CNT_W-1:0] RL_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    HALT_WAIT,
    ACCESS,
    READ_WAIT,
    RESPOND
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              settled_q, settled_d;
  logic              rd_q, rd_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [15:0]       txn_q, txn_d;
  logic              oor;

  assign oor = {1'b0, CMD_ADDR} >= DEPTH_L;

  always_ff @(posedge CK_REF or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      settled_q <= 1'b0;
      rd_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      txn_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      settled_q <= settled_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      txn_q     <= txn_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    settled_d = settled_q;
    rd_d      = rd_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    txn_d     = txn_q;
    unique case (state_q)
      IDLE: begin
        if (!DBG_HOLD) settled_d = 1'b0;
        if (CMD_VALID) begin
          rd_d    = CMD_READ_WRN;
          addr_d  = CMD_ADDR;
          wdata_d = CMD_WDATA;
          rdata_d = '0;
          err_d   = 1'b0;
          if (oor) begin
            err_d   = 1'b1;
            state_d = RESPOND;
          end else if (settled_q && DBG_HOLD) begin
            // Halt still held from the previous command: skip the drain.
            state_d = ACCESS;
          end else begin
            cnt_d   = HS_LOAD;
            state_d = HALT_WAIT;
          end
        end
      end
      HALT_WAIT: begin
        if (cnt_q == '0) begin
          settled_d = 1'b1;
          state_d   = ACCESS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACCESS: begin
        if (!rd_q) begin
          state_d = RESPOND;
        end else if (READ_LATENCY == 0) begin
          rdata_d = MEM_DATA_IN;
          state_d = RESPOND;
        end else begin
          cnt_d   = RL_LOAD;
          state_d = READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = MEM_DATA_IN;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESPOND: begin
        if (RSP_READY) begin
          txn_d   = txn_q + 16'd1;
          state_d = IDLE;
          if (!DBG_HOLD) settled_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign CMD_READY    = (state_q == IDLE) && !RST;
  assign BUS_OWN      = (state_q == ACCESS) || (state_q == READ_WAIT);
  assign MEM_ADDR     = BUS_OWN ? addr_q : '0;
  assign MEM_DATA_OUT = (BUS_OWN && !rd_q) ? wdata_q : '0;
  assign MEM_READ_WRN = !((state_q == ACCESS) && !rd_q);
  assign RSP_VALID    = (state_q == RESPOND);
  assign RSP_RDATA    = RSP_VALID ? rdata_q : '0;
  assign RSP_ERR      = RSP_VALID && err_q;
  assign HALT_REQ     = (state_q == HALT_WAIT) || settled_q;
  assign TXN_COUNT    = txn_q;

endmodule

// File: tb/tb_debug_mem_master.sv
// Randomized bench for debug_mem_master against a transaction-level
// model of memory contents, latency, halt and response behaviour.
module tb_debug_mem_master;

  localparam int DEPTH = 10;
  localparam int HS    = 4;
  localparam int RL    = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_rd;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        hold;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        halt_req, bus_own, mem_rwn;
  logic [31:0] mem_addr, mem_dout, mem_din;
  logic [15:0] txn_count;

  int checks = 0;
  int failures = 0;
  int idle_viol = 0;
  int exp_txn = 0;
  bit halted = 0;

  logic [31:0] mem [DEPTH] = '{default: 32'h0};
  logic [31:0] ref_mem [DEPTH] = '{default: 32'h0};

  always #5 clk = ~clk;

  debug_mem_master #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH),
    .HALT_SETTLE(HS), .READ_LATENCY(RL)
  ) dut (
    .CK_REF(clk), .RST(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_READ_WRN(cmd_rd), .CMD_ADDR(cmd_addr),
    .CMD_WDATA(cmd_wdata), .DBG_HOLD(hold),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
    .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .HALT_REQ(halt_req), .BUS_OWN(bus_own),
    .MEM_ADDR(mem_addr), .MEM_DATA_OUT(mem_dout),
    .MEM_READ_WRN(mem_rwn), .MEM_DATA_IN(mem_din),
    .TXN_COUNT(txn_count)
  );

  assign mem_din = (mem_addr < DEPTH) ? mem[mem_addr[3:0]] : 32'h0;

  always @(posedge clk)
    if (bus_own && !mem_rwn && mem_addr < DEPTH)
      mem[mem_addr[3:0]] <= mem_dout;

  always @(negedge clk)
    if (!rst) begin
      if (!bus_own && (mem_addr != 0 || mem_dout != 0 || !mem_rwn))
        idle_viol++;
      if (bus_own && rsp_valid) idle_viol++;
    end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_hold(input bit v);
    @(negedge clk);
    hold = v;
    if (!v && halted) begin
      #1 chk("hold_fall_same", halt_req, 1);
      @(negedge clk);
      chk("hold_fall_next", halt_req, 0);
    end
    if (!v) halted = 0;
  endtask

  task automatic do_cmd(input bit rd, input logic [31:0] addr,
                        input logic [31:0] wd, input int bp);
    bit err = (addr >= DEPTH);
    int n = 0, strobes = 0, bus = 0, pre = 0, hi = 0, stab = 0;
    int exp_lat, w = 0;
    logic [31:0] s_addr = 0, s_data = 0, b_addr = 0, r0;
    exp_lat = err ? 1 : ((halted ? 2 : HS + 2) + (rd ? RL : 0));
    @(negedge clk);
    cmd_valid = 1; cmd_rd = rd; cmd_addr = addr; cmd_wdata = wd;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    chk("cmd_ready", cmd_ready, 1);
    do begin
      @(negedge clk);
      cmd_valid = 0;
      n++;
      if (!mem_rwn) begin strobes++; s_addr = mem_addr; s_data = mem_dout; end
      if (bus_own) begin bus++; b_addr = mem_addr; end
      else if (halt_req && !rsp_valid) pre++;
      if (halt_req) hi++;
    end while (!rsp_valid && n < 64);
    chk("rsp_timeout", rsp_valid, 1);
    chk("latency", n, exp_lat);
    chk("strobes", strobes, (!rd && !err) ? 1 : 0);
    chk("bus_cycles", bus, err ? 0 : 1 + (rd ? RL : 0));
    chk("halt_pre", pre, (!err && !halted) ? HS : 0);
    chk("halt_hi", hi, (!err || halted) ? n : 0);
    if (!err) chk("bus_addr", b_addr, addr);
    if (!rd && !err) begin
      chk("wr_addr", s_addr, addr);
      chk("wr_data", s_data, wd);
      ref_mem[addr[3:0]] = wd;
    end
    chk("rsp_err", rsp_err, err);
    chk("rsp_rdata", rsp_rdata, (rd && !err) ? ref_mem[addr[3:0]] : 0);
    r0 = rsp_rdata;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata != r0 || cmd_ready || bus_own || !mem_rwn)
        stab++;
    end
    chk("bp_stable", stab, 0);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    if (!err) halted = 1;
    if (!hold) halted = 0;
    exp_txn = (exp_txn + 1) & 16'hFFFF;
    chk("rsp_drop", rsp_valid, 0);
    chk("txn_count", txn_count, exp_txn);
    chk("halt_after", halt_req, halted);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int mm = 0;
    rst = 1; cmd_valid = 0; cmd_rd = 0; cmd_addr = 0; cmd_wdata = 0;
    hold = 0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {cmd_ready, rsp_valid, rsp_err, halt_req, bus_own, mem_rwn},
        6'b000001);
    chk("rst_data", {rsp_rdata, mem_addr}, 0);
    chk("rst_dout", mem_dout, 0);
    chk("rst_txn", txn_count, 0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    do_cmd(0, 3, 32'hDEADBEEF, 0);
    do_cmd(0, 3, 32'h12345678, 1);
    do_cmd(1, 3, 32'h0, 0);
    do_cmd(1, 10, 32'h0, 0);
    do_cmd(0, DEPTH - 1, 32'hCAFEF00D, 2);
    do_cmd(1, DEPTH - 1, 32'h0, 0);
    do_cmd(0, 32'hFFFF_FFFF, 32'h1, 0);

    set_hold(1);
    repeat (3) @(negedge clk);
    chk("hold_no_self_halt", halt_req, 0);
    do_cmd(0, 1, 32'h11111111, 0);
    do_cmd(0, 2, 32'h22222222, 0);
    do_cmd(1, 1, 32'h0, 5);
    do_cmd(1, 12, 32'h0, 0);
    set_hold(0);

    for (int i = 0; i < 40; i++) begin
      bit rd = 1'($urandom_range(0, 1));
      logic [31:0] a = ($urandom_range(0, 7) == 0) ? $urandom
                                                   : $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 3) == 0) set_hold(!hold);
      do_cmd(rd, a, $urandom, $urandom_range(0, 5));
    end
    set_hold(0);

    @(negedge clk);
    cmd_valid = 1; cmd_rd = 0; cmd_addr = 5; cmd_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (!bus_own && n < 20) begin @(negedge clk); n++; end
    chk("reach_access", bus_own, 1);
    rst = 1;
    #1;
    chk("rst_mid_rwn", mem_rwn, 1);
    chk("rst_mid_bus", bus_own, 0);
    chk("rst_mid_halt", halt_req, 0);
    chk("rst_mid_rsp", rsp_valid, 0);
    chk("rst_mid_txn", txn_count, 0);
    @(negedge clk);
    rst = 0;
    exp_txn = 0;
    halted = 0;
    do_cmd(1, 5, 32'h0, 0);
    do_cmd(0, 5, 32'h5A5A5A5A, 1);
    do_cmd(1, 5, 32'h0, 0);

    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== ref_mem[i]) mm++;
    chk("mem_contents", mm, 0);
    chk("bus_idle_viol", idle_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
